// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file and its clear sequencer.
// Pure declarations; no latency or backpressure of its own.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Index 0 is hardwired to zero and indices past the implemented count do not exist.
  function automatic logic idx_in_range(input int idx, input int num_regs);
    return (idx != 0) && (idx < num_regs);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks indices 1..NUM_REGS-1 one per cycle after a ClearReq, then pulses done.
// Busy for NUM_REGS-1 cycles starting the cycle after the request; requests outside IDLE are dropped.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Counter parks on the last index once the walk is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_IDLE && clear_req) begin
      cnt <= ADDR_W'(1);
    end else if (state == ST_CLEAR && cnt != LAST_IDX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    busy       = 1'b0;
    clear_done = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = cnt;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
      end
      ST_DONE:  clear_done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/regfile_gen.sv
// Register file, index 0 hardwired to zero, two registered read ports (1-cycle latency) and a bulk clear.
// While Busy, writes and reads are dropped and ReadData holds; REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_gen
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RegDest,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RegSource,
  input  logic [ADDR_W-1:0] RegSupport,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              ClearReq,
  output logic              Busy,
  output logic              ClearDone
);

  logic              busy;
  logic              clear_done;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd1_nxt;
  logic [DATA_W-1:0] rd2_nxt;
  logic [DATA_W-1:0] mem [1:NUM_REGS-1];

  regfile_clear_seq #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (ClearReq),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx)
  );

  assign Busy      = busy;
  assign ClearDone = clear_done;
  assign wr_ok     = RegWrite && !busy && idx_in_range(int'(RegDest), NUM_REGS);
  assign rd_ok     = RdEn && !busy;

  // Clear and write never coincide: writes are only accepted while not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (clr_en && clr_idx == ADDR_W'(i)) begin
          mem[i] <= '0;
        end else if (wr_ok && RegDest == ADDR_W'(i)) begin
          mem[i] <= WriteData;
        end
      end
    end
  end

  // Unmatched indices (0 and anything past NUM_REGS-1) fall through to zero.
  always_comb begin
    rd1_nxt = '0;
    rd2_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (RegSource == ADDR_W'(i)) rd1_nxt = mem[i];
      if (RegSupport == ADDR_W'(i)) rd2_nxt = mem[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && RegDest == RegSource) rd1_nxt = WriteData;
    if (wr_ok && RegDest == RegSupport) rd2_nxt = WriteData;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
    end else if (rd_ok) begin
      ReadData1 <= rd1_nxt;
      ReadData2 <= rd2_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_gen.sv
// Bench for regfile_gen: a 32-register and a 16-register instance share stimulus, checked by a transaction model.
module tb_regfile_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  RegDest = '0;
  logic [31:0] WriteData = '0;
  logic        RdEn = 1'b0;
  logic [4:0]  RegSource = '0;
  logic [4:0]  RegSupport = '0;
  logic        ClearReq = 1'b0;

  logic [31:0] rd1 [2];
  logic [31:0] rd2 [2];
  logic        busy [2];
  logic        done [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_gen dut_a (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .RegDest(RegDest), .WriteData(WriteData),
    .RdEn(RdEn), .RegSource(RegSource), .RegSupport(RegSupport),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .ClearReq(ClearReq), .Busy(busy[0]), .ClearDone(done[0])
  );

  regfile_gen #(.NUM_REGS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .RegDest(RegDest), .WriteData(WriteData),
    .RdEn(RdEn), .RegSource(RegSource), .RegSupport(RegSupport),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .ClearReq(ClearReq), .Busy(busy[1]), .ClearDone(done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [31:0] m_mem [2][32];
  logic [31:0] m_rd1 [2];
  logic [31:0] m_rd2 [2];
  int          m_left [2];
  bit          m_done [2];

  function automatic int n_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit m_valid(input int k, input logic [4:0] idx);
    return (idx != 0) && (int'(idx) < n_of(k));
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [4:0] idx, input bit wq);
    if (!m_valid(k, idx)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wq && RegDest == idx) return WriteData;
`endif
    return m_mem[k][idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit wq;
    bit idle;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 32; j++) m_mem[k][j] <= '0;
        m_rd1[k] <= '0;
        m_rd2[k] <= '0;
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        idle = (m_left[k] == 0);
        wq = idle && RegWrite && m_valid(k, RegDest);
        if (idle && RdEn) begin
          m_rd1[k] <= m_read(k, RegSource, wq);
          m_rd2[k] <= m_read(k, RegSupport, wq);
        end
        if (wq) m_mem[k][RegDest] <= WriteData;
        if (!idle) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) m_done[k] <= 1'b1;
        end else if (m_done[k]) begin
          m_done[k] <= 1'b0;
        end else if (ClearReq) begin
          for (int j = 0; j < 32; j++) m_mem[k][j] <= '0;
          m_left[k] <= n_of(k) - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_rd1_u%0d", k), rd1[k], m_rd1[k]);
      check($sformatf("model_rd2_u%0d", k), rd2[k], m_rd2[k]);
      check($sformatf("model_busy_u%0d", k), {31'b0, busy[k]}, {31'b0, m_left[k] != 0});
      check($sformatf("model_done_u%0d", k), {31'b0, done[k]}, {31'b0, m_done[k]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic w, input logic [4:0] d, input logic [31:0] data,
                      input logic r, input logic [4:0] a, input logic [4:0] b, input logic c);
    RegWrite = w; RegDest = d; WriteData = data;
    RdEn = r; RegSource = a; RegSupport = b; ClearReq = c;
    @(posedge clk); #1;
    RegWrite = 1'b0; RdEn = 1'b0; ClearReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int dc;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rd1", rd1[0], 32'h0);
    check("reset_busy", {31'b0, busy[0]}, 32'h0);
    check("reset_done", {31'b0, done[0]}, 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);

    // Basic write and two-port read
    step(1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8, 0, 0);
    check("rd_reg8", rd1[0], 32'hDEADBEEF);
    check("rd_reg0", rd2[0], 32'h0);

    // Index 0 and out-of-range indices
    step(1, 0, 32'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8, 0);
    check("rd_reg0_after_wr", rd1[0], 32'h0);
    check("rd_same_src_sup_a", rd2[0], 32'hDEADBEEF);
    step(1, 20, 32'h2020, 0, 0, 0, 0);
    step(0, 0, 0, 1, 20, 20, 0);
    check("rd_reg20_n32", rd1[0], 32'h2020);
    check("rd_reg20_n16_p1", rd1[1], 32'h0);
    check("rd_reg20_n16_p2", rd2[1], 32'h0);

    // Same-cycle write and read
    step(1, 9, 32'h1, 0, 0, 0, 0);
    step(1, 9, 32'hA5A5A5A5, 1, 9, 9, 0);
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd9", rd1[0], 32'hA5A5A5A5);
`else
    check("same_cycle_rd9", rd1[0], 32'h1);
`endif
    step(0, 0, 0, 1, 9, 0, 0);
    check("rd9_after", rd1[0], 32'hA5A5A5A5);

    // Hold while RdEn low
    step(1, 3, 32'h55, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0);
    check("hold_initial", rd1[0], 32'h55);
    step(1, 3, 32'h66, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 3, 0, 0);
      check($sformatf("hold_cycle%0d", i), rd1[0], 32'h55);
    end
    step(0, 0, 0, 1, 3, 0, 0);
    check("hold_reread", rd1[0], 32'h66);

    // Full clear with writes attempted while busy
    for (int i = 1; i < 32; i++) step(1, 5'(i), 32'h1000_0000 | 32'(i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    bc = 0;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      RegWrite = busy[0]; RegDest = 5; WriteData = 32'hFFFF_FFFF;
      RdEn = busy[0]; RegSource = 5; RegSupport = 6;
      if (busy[0]) bc++;
      if (done[0]) dc++;
      @(posedge clk); #1;
    end
    RegWrite = 1'b0; RdEn = 1'b0;
    check("clr_busy_cycles", 32'(bc), 32'd31);
    check("clr_done_pulses", 32'(dc), 32'd1);
    for (int i = 0; i < 32; i += 2) begin
      step(0, 0, 0, 1, 5'(i), 5'(i + 1), 0);
      check($sformatf("clr_rd_%0d", i), rd1[0], 32'h0);
      check($sformatf("clr_rd_%0d", i + 1), rd2[0], 32'h0);
    end

    // Simultaneous write and clear request: clear wins
    step(1, 7, 32'h77, 0, 0, 0, 1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (done[0]) seen = 1'b1;
    end
    check("wr_clr_done_seen", {31'b0, seen}, 32'h1);
    step(0, 0, 0, 1, 7, 0, 0);
    check("wr_clr_rd7", rd1[0], 32'h0);

    // Reset in the middle of a clear
    step(1, 4, 32'h44, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 4, 0);
    check("pre_abort_rd4", rd1[0], 32'h44);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (9) @(posedge clk);
    #2;
    check("abort_busy_before", {31'b0, busy[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy[0]}, 32'h0);
    check("abort_done", {31'b0, done[0]}, 32'h0);
    check("abort_rd1", rd1[0], 32'h0);
    check("abort_rd2", rd2[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done[0]) dc++;
    end
    check("abort_no_done", 32'(dc), 32'd0);
    step(0, 0, 0, 1, 4, 9, 0);
    check("abort_rd4", rd1[0], 32'h0);
    check("abort_rd9", rd2[0], 32'h0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_gen.md
REGFILE_GEN -- requirements
Module: regfile_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width.
REQ-003 SHALL have parameter NUM_REGS, default 32, implemented registers, legal range 2..2**ADDR_W.
REQ-004 SHALL have clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have RegWrite  input  1  write enable.
REQ-007 SHALL have RegDest  input  ADDR_W  write index.
REQ-008 SHALL have WriteData  input  DATA_W  write data.
REQ-009 SHALL have RdEn  input  1  operand-capture strobe, issued in decode.
REQ-010 SHALL have RegSource  input  ADDR_W  read index, port 1.
REQ-011 SHALL have RegSupport  input  ADDR_W  read index, port 2.
REQ-012 SHALL have ReadData1  output  DATA_W  registered operand 1.
REQ-013 SHALL have ReadData2  output  DATA_W  registered operand 2.
REQ-014 SHALL have ClearReq  input  1  single-cycle request to zero all registers.
REQ-015 SHALL have Busy  output  1  high while a clear sequence runs.
REQ-016 SHALL have ClearDone  output  1  one-cycle pulse when a clear completes.

Function
REQ-017 SHALL write WriteData to register RegDest at the clk edge where RegWrite=1 and Busy=0.
REQ-018 SHALL hardwire index 0 to zero: writes to 0 ignored, reads of 0 return 0.
REQ-019 SHALL ignore writes and return 0 on reads for any index >= NUM_REGS; never drive X or Z.
REQ-020 SHALL load ReadData1/ReadData2 at the clk edge where RdEn=1 and Busy=0 (latency 1 cycle); otherwise hold the previous value.
REQ-021 SHALL resolve two read ports independently; RegSource equal to RegSupport returns the same value on both.
REQ-022 SHALL implement clear FSM states IDLE, CLEAR, DONE.
REQ-023 SHALL move IDLE->CLEAR on ClearReq=1, loading index counter with 1; Busy=1 from the next cycle.
REQ-024 SHALL, in CLEAR, zero register[counter] each cycle and increment; move to DONE after clearing index NUM_REGS-1 (NUM_REGS-1 CLEAR cycles).
REQ-025 SHALL hold DONE one cycle with ClearDone=1, Busy=0, then return to IDLE.
REQ-026 SHALL ignore ClearReq outside IDLE.
REQ-027 SHALL ignore RegWrite and RdEn while Busy=1; ReadData1/2 hold.
REQ-028 SHALL, on simultaneous ClearReq and RegWrite in IDLE, perform the write, then clear (write is overwritten).

Reset
REQ-029 SHALL, on rst_n=0, immediately zero all registers, ReadData1, ReadData2, counter; FSM to IDLE; Busy=0, ClearDone=0.
REQ-030 SHALL abort a clear sequence on reset mid-operation with no ClearDone pulse.

Configuration
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, return WriteData on a read port when RdEn and a qualified write (REQ-017) target the same nonzero, in-range index in the same cycle.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return the pre-write value in that case.

Structure
REQ-033 SHALL place the clear-FSM state enum and default DATA_W/ADDR_W/NUM_REGS constants in shared package regfile_pkg.
REQ-034 SHALL implement the clear FSM and counter as sub-module regfile_clear_seq; storage and read muxing stay in regfile_gen.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF to reg 8, RdEn with RegSource=8, RegSupport=0 -> next cycle ReadData1=0xDEADBEEF, ReadData2=0.
REQ-036 SHALL cover: write 0x1234 to reg 0, then read reg 0 -> 0; NUM_REGS=16, write reg 20, read reg 20 -> 0.
REQ-037 SHALL cover: same-cycle write 0xA5A5A5A5 to reg 9 with RdEn RegSource=9, reg 9 previously 0x1 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x1 without.
REQ-038 SHALL cover: fill regs 1..31 with nonzero, pulse ClearReq -> Busy high 31 cycles, ClearDone one cycle, all regs read 0; RegWrite during Busy has no effect.
REQ-039 SHALL cover: rst_n low at CLEAR cycle 10 -> Busy=0, no ClearDone, all registers and outputs 0 immediately.
REQ-040 SHALL cover: RdEn low for 5 cycles after a read of 0x55 while reg changes to 0x66 -> ReadData1 stays 0x55.
